// File: rtl/addsub_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// FSM state encoding, NZVC flag bit positions and the default operand size.
package addsub_pkg;

    localparam int DEFAULT_NBYTES = 4;

    // Bit positions of the condition codes when packed into a 4-bit NZVC vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/addsub8_cin.sv
// Combinational 8-bit add/subtract slice with carry-in. Subtraction inverts b
// and relies on the caller seeding cin=1 for the least-significant byte, so
// cout is the inverted borrow. c7 exposes the carry into bit 7 so the caller
// can derive signed overflow for the most-significant byte.
module addsub8_cin (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout,
    output logic       c7
);

    logic [7:0] bEff;
    logic [7:0] lowSum;
    logic [1:0] topSum;

    // Split the add at bit 7 so the carry into the sign bit is visible
    always_comb begin
        bEff   = sub ? ~b : b;
        lowSum = {1'b0, a[6:0]} + {1'b0, bEff[6:0]} + {7'd0, cin};
        topSum = {1'b0, a[7]} + {1'b0, bEff[7]} + {1'b0, lowSum[7]};
        s      = {topSum[0], lowSum[6:0]};
        cout   = topSum[1];
        c7     = lowSum[7];
    end

endmodule

// File: rtl/multiprec_addsub_seq.sv
// Byte-serial multi-precision add/subtract unit. Operands are latched on the
// input handshake, one byte is processed per clock (LSB first) through a
// single 8-bit slice with carry chaining, and the full-width result plus NZVC
// flags are held until the consumer accepts them.
module multiprec_addsub_seq
    import addsub_pkg::*;
#(
    parameter int NBYTES = DEFAULT_NBYTES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] x,
    input  logic [8*NBYTES-1:0] y,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] result,
    output logic                ccn,
    output logic                ccz,
    output logic                ccv,
    output logic                ccc
);

    localparam int W  = 8 * NBYTES;
    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  y_q, y_d;
    logic          sub_q, sub_d;
    logic          carry_q, carry_d;
    logic          zacc_q, zacc_d;
    logic [W-1:0]  result_q, result_d;
    logic [3:0]    flags_q, flags_d;

    logic [7:0]    sliceA;
    logic [7:0]    sliceB;
    logic [7:0]    sliceS;
    logic          sliceCout;
    logic          sliceC7;
    logic [KW+2:0] bitBase;

    assign bitBase = {k_q, 3'b000};
    assign sliceA  = x_q[bitBase +: 8];
    assign sliceB  = y_q[bitBase +: 8];

    addsub8_cin u_slice (
        .a    (sliceA),
        .b    (sliceB),
        .sub  (sub_q),
        .cin  (carry_q),
        .s    (sliceS),
        .cout (sliceCout),
        .c7   (sliceC7)
    );

    // Next-state logic: accept in IDLE, chain one byte per cycle in BUSY,
    // hold the result in DONE until the consumer takes it
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        x_d      = x_q;
        y_d      = y_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    y_d     = y;
                    sub_d   = sub;
                    k_d     = '0;
                    carry_d = sub;
                    zacc_d  = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                result_d[bitBase +: 8] = sliceS;
                carry_d = sliceCout;
                zacc_d  = zacc_q & (sliceS == 8'h00);
                if (k_q == K_LAST) begin
                    flags_d[FLAG_N] = sliceS[7];
                    flags_d[FLAG_Z] = zacc_q & (sliceS == 8'h00);
                    flags_d[FLAG_V] = sliceC7 ^ sliceCout;
                    flags_d[FLAG_C] = sliceCout;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) & ~rst;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign ccn       = flags_q[FLAG_N];
    assign ccz       = flags_q[FLAG_Z];
    assign ccv       = flags_q[FLAG_V];
    assign ccc       = flags_q[FLAG_C];

endmodule

// File: tb/tb_multiprec_addsub_seq.sv
// Testbench for multiprec_addsub_seq: directed corner cases, backpressure,
// mid-operation reset and a randomized regression against a W-bit model.
module tb_multiprec_addsub_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         ccn, ccz, ccv, ccc;
    logic [3:0]   flags;

    int total = 0;
    int bad   = 0;

    assign flags = {ccn, ccz, ccv, ccc};

    // Free-running clock
    always #5 clk = ~clk;

    multiprec_addsub_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ccn       (ccn),
        .ccz       (ccz),
        .ccv       (ccv),
        .ccc       (ccc)
    );

    // One comparison: counts it, and on mismatch counts and reports the failure
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact signed/unsigned arithmetic, returns {N,Z,V,C,result}
    function automatic logic [W+3:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
        logic [W-1:0] r;
        logic [W:0]   wide;
        longint       sa, sb, exact, lim;
        logic         n, z, v, c;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = longint'(1) <<< (W - 1);
        if (s) begin
            r     = a - b;
            exact = sa - sb;
            c     = (a >= b);
        end else begin
            wide  = {1'b0, a} + {1'b0, b};
            r     = wide[W-1:0];
            exact = sa + sb;
            c     = wide[W];
        end
        v = (exact >= lim) || (exact < -lim);
        n = r[W-1];
        z = (r == '0);
        return {n, z, v, c, r};
    endfunction

    // Issue one operation, check latency and outputs, optionally hold off the
    // consumer while poking in_valid, then complete the handshake
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 input logic [W-1:0] expR, input logic [3:0] expF,
                                 input int holdCycles);
        int lat;
        @(negedge clk);
        checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        x = a;
        y = b;
        sub = s;
        @(negedge clk);
        in_valid = 1'b0;
        x = $urandom;
        y = $urandom;
        sub = ~s;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'(NB));
        checkOutput("out_valid", 64'(out_valid), 64'd1);
        checkOutput("result", 64'(result), 64'(expR));
        checkOutput("nzvc", 64'(flags), 64'(expF));
        checkOutput("in_ready_done", 64'(in_ready), 64'd0);
        for (int i = 0; i < holdCycles; i++) begin
            in_valid = 1'b1;
            x = $urandom;
            y = $urandom;
            @(negedge clk);
            checkOutput("hold_result", 64'(result), 64'(expR));
            checkOutput("hold_nzvc", 64'(flags), 64'(expF));
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("post_hs_valid", 64'(out_valid), 64'd0);
        checkOutput("post_hs_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    // Directed sequence followed by randomized regression
    initial begin
        logic [W+3:0] m;
        logic [W-1:0] ra, rb;
        logic         rs;
        logic         seen;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x = '0;
        y = '0;
        sub = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_result", 64'(result), 64'd0);
        checkOutput("rst_nzvc", 64'(flags), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_release_in_ready", 64'(in_ready), 64'd1);

        applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 4'b0000, 0);
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0101, 0);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1010, 0);
        applyStimulus(32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 4'b1000, 0);
        applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 4'b0101, 0);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b0011, 5);

        // Reset arriving in the second BUSY cycle must abandon the operation
        @(negedge clk);
        in_valid = 1'b1;
        x = 32'hDEAD_BEEF;
        y = 32'h0101_0101;
        sub = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_result", 64'(result), 64'd0);
        checkOutput("midrst_nzvc", 64'(flags), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        checkOutput("midrst_no_result", 64'(seen), 64'd0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 0) rb = ra;
            rs = 1'($urandom_range(0, 1));
            m = refModel(ra, rb, rs);
            applyStimulus(ra, rb, rs, m[W-1:0], m[W+3:W], $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
